// File: rtl/dmem_arbiter_if.sv
// Word-access requester port of the data-memory arbiter: request, word payload and completion.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;

  modport master (output req, we, addr, wdata, input rdata, done);
  modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises 32-bit CPU/debug word accesses into four big-endian byte beats.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned/out-of-range addresses with err.
module dmem_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  cpu,
  dmem_arbiter_if.slave  dbg,
  output logic           m_we,
  output logic [5:0]     m_addr,
  output logic [7:0]     m_wdata,
  input  logic [7:0]     m_rdata,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  beat;
  logic        gnt;        // 0 = cpu, 1 = dbg
  logic        prio;       // port that wins a tie next time
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [23:0] rd_buf;
  logic [31:0] cpu_rdata, dbg_rdata;

  logic        any_req;
  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic        req_err;

  assign any_req   = cpu.req | dbg.req;
  assign win       = (cpu.req && dbg.req) ? prio : dbg.req;
  assign sel_we    = win ? dbg.we    : cpu.we;
  assign sel_addr  = win ? dbg.addr  : cpu.addr;
  assign sel_wdata = win ? dbg.wdata : cpu.wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  logic lat_err;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
  endfunction

  assign req_err = addr_bad(sel_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lat_err <= 1'b0;
    else if (state == IDLE && any_req)
      lat_err <= req_err;
  end

  assign err = (state == DONE) && lat_err;
`else
  assign req_err = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = req_err ? DONE : XFER;
      XFER:    if (beat == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: grant, round-robin pointer, beat counter and the architectural read words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= 2'd0;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      cpu_rdata <= 32'd0;
      dbg_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          beat <= 2'd0;
          if (any_req) begin
            gnt  <= win;
            prio <= ~win;
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3 && !lat_we) begin
            if (gnt) dbg_rdata <= {rd_buf, m_rdata};
            else     cpu_rdata <= {rd_buf, m_rdata};
          end
        end
        default: beat <= 2'd0;
      endcase
    end
  end

  // Data: request payload held for the whole transfer, read bytes shifted in MSB first
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
    if (state == XFER)
      rd_buf <= {rd_buf[15:0], m_rdata};
  end

  always_comb begin
    m_we      = 1'b0;
    m_addr    = 6'd0;
    m_wdata   = 8'd0;
    cpu.done  = 1'b0;
    dbg.done  = 1'b0;
    cpu.rdata = cpu_rdata;
    dbg.rdata = dbg_rdata;
    if (state == XFER) begin
      m_we   = lat_we;
      m_addr = lat_addr[5:0] + {4'd0, beat};
      if (lat_we) begin
        case (beat)
          2'd0:    m_wdata = lat_wdata[31:24];
          2'd1:    m_wdata = lat_wdata[23:16];
          2'd2:    m_wdata = lat_wdata[15:8];
          default: m_wdata = lat_wdata[7:0];
        endcase
      end
    end
    if (state == DONE) begin
      cpu.done = ~gnt;
      dbg.done = gnt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level memory model, directed scenarios and random traffic.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_we;
  logic [5:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic       err;

  always #5 clk = ~clk;

  dmem_arbiter_if cpu ();
  dmem_arbiter_if dbg ();

  dmem_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cpu    (cpu),
    .dbg    (dbg),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .err    (err)
  );

  logic [7:0] mem [64];
  logic [7:0] refm[64];
  assign m_rdata = mem[m_addr];
  always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;

  typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
  exp_t        cq[$];
  exp_t        dq[$];
  int          order_q[$];
  logic [31:0] last_rd[2];
  int          done_cnt[2];
  int          checks = 0;
  int          errors = 0;
  bit          mwe_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % 4 != 0) || (a >= 64);
`else
    return (a != a + 1) ? 1'b0 : 1'b1;
`endif
  endfunction

  // Reference: whole-word effect on the byte array, big-endian, addresses modulo 64
  task automatic model_issue(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   a;
    e.err = model_err(addr);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          a = (int'(addr % 64) + i) % 64;
          refm[a] = 8'((wdata >> (8 * (3 - i))) & 32'hff);
        end
      end else begin
        last_rd[p] = 32'd0;
        for (int i = 0; i < 4; i++) begin
          a = (int'(addr % 64) + i) % 64;
          last_rd[p] = last_rd[p] * 256 + {24'd0, refm[a]};
        end
      end
    end
    e.rdata = last_rd[p];
    if (p) dq.push_back(e);
    else   cq.push_back(e);
  endtask

  task automatic sb_pop(input bit p, input logic [31:0] rd, input logic e);
    exp_t x;
    done_cnt[p]++;
    order_q.push_back(int'(p));
    if ((p && dq.size() == 0) || (!p && cq.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done port %0d: got done=1, required done=0", p);
    end else begin
      if (p) x = dq.pop_front();
      else   x = cq.pop_front();
      chk(p ? "dbg_rdata" : "cpu_rdata", rd, x.rdata);
      chk(p ? "dbg_err" : "cpu_err", {31'd0, e}, {31'd0, x.err});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_we) mwe_seen = 1;
      if (cpu.done && dbg.done) chk("both_done", 32'd1, 32'd0);
      if (err && !(cpu.done || dbg.done)) chk("err_without_done", {31'd0, err}, 32'd0);
      if (cpu.done) sb_pop(0, cpu.rdata, err);
      if (dbg.done) sb_pop(1, dbg.rdata, err);
    end
  end

  task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin dbg.req = req; dbg.we = we; dbg.addr = addr; dbg.wdata = wdata; end
    else   begin cpu.req = req; cpu.we = we; cpu.addr = addr; cpu.wdata = wdata; end
  endtask

  task automatic do_txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit lat_chk, input int drop_after);
    int n;
    bit got;
    bit e;
    @(negedge clk);
    e = model_err(addr);
    drive(p, 1'b1, we, addr, wdata);
    model_issue(p, we, addr, wdata);
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (lat_chk && n == 1) drive(p, 1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
      if (drop_after > 0 && n == drop_after) begin
        if (p) dbg.req = 1'b0;
        else   cpu.req = 1'b0;
      end
      got = p ? dbg.done : cpu.done;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    else if (lat_chk) chk("latency", n, e ? 32'd1 : 32'd5);
    if (p) dbg.req = 1'b0;
    else   cpu.req = 1'b0;
  endtask

  task automatic rand_driver(input bit p, input int cnt);
    int          g;
    int          lo;
    logic [31:0] hi;
    for (int i = 0; i < cnt; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) @(negedge clk);
      lo = p ? $urandom_range(32, 60) : $urandom_range(0, 28);
      hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      do_txn(p, $urandom_range(0, 1) == 1, {hi[25:0], lo[5:0]}, $urandom, 0, 0);
    end
  endtask

  task automatic compare_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== refm[i]) bad++;
    chk(name, bad, 32'd0);
  endtask

  initial begin
    int snap;
    int cd, dd, n;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 8'($urandom);
      refm[i] = mem[i];
    end
    last_rd[0] = 0; last_rd[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    repeat (2) @(negedge clk);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", {26'd0, m_addr}, 32'd0);
    chk("rst_m_wdata", {24'd0, m_wdata}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_c_done", {31'd0, cpu.done}, 32'd0);
    chk("rst_d_done", {31'd0, dbg.done}, 32'd0);
    chk("rst_c_rdata", cpu.rdata, 32'd0);
    chk("rst_d_rdata", dbg.rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(0, 1, 32'd8, 32'h11223344, 1, 0);
    do_txn(0, 0, 32'd8, 32'h0, 1, 0);
    chk("mem8",  {24'd0, mem[8]},  32'h11);
    chk("mem9",  {24'd0, mem[9]},  32'h22);
    chk("mem10", {24'd0, mem[10]}, 32'h33);
    chk("mem11", {24'd0, mem[11]}, 32'h44);

    mwe_seen = 0;
    do_txn(0, 1, 32'd62, 32'hAABBCCDD, 1, 0);
    repeat (2) @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misaligned_no_mwe", {31'd0, mwe_seen}, 32'd0);
`else
    chk("wrap62", {24'd0, mem[62]}, 32'hAA);
    chk("wrap63", {24'd0, mem[63]}, 32'hBB);
    chk("wrap0",  {24'd0, mem[0]},  32'hCC);
    chk("wrap1",  {24'd0, mem[1]},  32'hDD);
`endif
    compare_mem("mem_after_wrap");

    snap = done_cnt[1];
    do_txn(1, 1, 32'd44, 32'h5566_7788, 1, 2);
    repeat (8) @(negedge clk);
    chk("drop_done_once", done_cnt[1] - snap, 32'd1);
    do_txn(1, 0, 32'd44, 32'h0, 1, 0);

    fork
      rand_driver(0, 25);
      rand_driver(1, 25);
    join
    repeat (4) @(negedge clk);
    compare_mem("mem_after_random");
    chk("cq_empty", cq.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);

    do_txn(0, 1, 32'd0, 32'h01020304, 0, 0);
    @(negedge clk);
    cpu.we = 1'b1; cpu.addr = 32'd0; cpu.wdata = 32'hCAFEBABE; cpu.req = 1'b1;
    repeat (3) @(negedge clk);
    chk("beat2_addr", {26'd0, m_addr}, 32'd2);
    chk("beat2_we", {31'd0, m_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_m_we", {31'd0, m_we}, 32'd0);
    chk("abort_m_addr", {26'd0, m_addr}, 32'd0);
    chk("abort_m_wdata", {24'd0, m_wdata}, 32'd0);
    chk("abort_c_done", {31'd0, cpu.done}, 32'd0);
    chk("abort_c_rdata", cpu.rdata, 32'd0);
    chk("abort_d_rdata", dbg.rdata, 32'd0);
    cpu.req = 1'b0;
    refm[0] = 8'hCA; refm[1] = 8'hFE;
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_mem0", {24'd0, mem[0]}, 32'hCA);
    chk("abort_mem1", {24'd0, mem[1]}, 32'hFE);
    chk("abort_mem2", {24'd0, mem[2]}, 32'h03);
    chk("abort_mem3", {24'd0, mem[3]}, 32'h04);

    // Both ports held: expect C, D, C, D starting from post-reset CPU priority
    cpu.we = 1'b0; cpu.addr = 32'd8;
    dbg.we = 1'b0; dbg.addr = 32'd40;
    model_issue(0, 0, 32'd8, 0);  model_issue(0, 0, 32'd8, 0);
    model_issue(1, 0, 32'd40, 0); model_issue(1, 0, 32'd40, 0);
    order_q.delete();
    cpu.req = 1'b1; dbg.req = 1'b1;
    cd = 0; dd = 0; n = 0;
    while ((cd < 2 || dd < 2) && n < 200) begin
      @(negedge clk);
      n++;
      if (cpu.done) begin cd++; if (cd == 2) cpu.req = 1'b0; end
      if (dbg.done) begin dd++; if (dd == 2) dbg.req = 1'b0; end
    end
    cpu.req = 1'b0; dbg.req = 1'b0;
    repeat (8) @(negedge clk);
    chk("rr_count", order_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < order_q.size()) ? order_q[i] : -1, i % 2);
    compare_mem("mem_final");
    chk("cq_empty_end", cq.size(), 32'd0);
    chk("dq_empty_end", dq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with all other ports as listed in REQ-002 to REQ-008.
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-002 CPU port (port 0):
- c_req  in  1  request; held high until c_done.
- c_we  in  1  1 = write word, 0 = read word.
- c_addr  in  32  byte address of the MSB byte.
- c_wdata  in  32  write word.
REQ-003 CPU port (port 0) outputs:
- c_rdata  out  32  read word.
- c_done  out  1  one-cycle completion pulse.
REQ-004 Debug port (port 1) inputs:
- d_req  in  1  request; held high until d_done.
- d_we  in  1  1 = write word, 0 = read word.
- d_addr  in  32  byte address of the MSB byte.
- d_wdata  in  32  write word.
REQ-005 Debug port (port 1) outputs:
- d_rdata  out  32  read word.
- d_done  out  1  one-cycle completion pulse.
REQ-006 Byte memory side, outputs:
- m_we  out  1  byte write strobe.
- m_addr  out  6  byte address into the 64-byte array.
- m_wdata  out  8  byte write data.
REQ-007 Byte memory side, input:
- m_rdata  in  8  combinational read of memory[m_addr].
REQ-008 Status output:
- err  out  1  access-error pulse, coincident with done.

Function
REQ-009 The FSM SHALL have three states, with transitions only on CLK rising edges:
- IDLE: if either request is high, go to XFER.
- XFER: four beats, counter 0..3; after beat 3, go to DONE.
- DONE: one cycle; go to IDLE.
REQ-010 In IDLE, the block SHALL grant one requester and latch its we, addr and wdata; later changes on that port's inputs SHALL NOT affect the transfer in progress.
REQ-011 Arbitration SHALL be round-robin: if both requests are high, the port not granted last wins; if one is high, it wins; after reset, the CPU port wins ties.
REQ-012 Beat n SHALL drive m_addr = (addr[5:0] + n) mod 64, so addresses wrap from 63 to 0.
REQ-013 Byte order SHALL be big-endian: beat 0 carries bits 31:24, beat 1 bits 23:16, beat 2 bits 15:8, beat 3 bits 7:0.
REQ-014 On a write, m_we SHALL be high during each of the four XFER cycles, with m_wdata set to the byte for that beat; m_we SHALL be low in all other states.
REQ-015 On a read, m_rdata SHALL be captured at the end of each beat; the granted port's rdata SHALL update with the full word at the DONE cycle and hold until that port's next completed read.
REQ-016 The done output of the granted port SHALL be high for exactly the DONE cycle; the other port's done SHALL stay low.
REQ-017 Latency SHALL be fixed: a request seen in IDLE at cycle k gives done at cycle k+5, with at least one IDLE cycle between transactions.
REQ-018 A request deasserted during XFER SHALL NOT abort the transfer, which SHALL complete normally including the done pulse.
REQ-019 Requests SHALL NOT be sampled in XFER or DONE; a requester holding req high through DONE SHALL start a new transaction from IDLE.
REQ-020 The non-granted port SHALL wait with no timeout, its req held high.

Reset
REQ-021 While Reset = 0, the block SHALL immediately force the following, regardless of CLK:
- state IDLE, beat counter 0, round-robin pointer to CPU priority;
- c_done, d_done, err, m_we = 0;
- m_addr, m_wdata = 0;
- c_rdata, d_rdata = 0.
REQ-022 A reset during XFER SHALL abort the transfer with no done pulse; bytes already written SHALL remain in memory.

Configuration
REQ-023 With DMEM_ALIGN_CHECK_EN defined, a request with addr[1:0] != 0 or addr[31:6] != 0 SHALL skip XFER (no m_we, rdata unchanged) and go from IDLE to DONE, pulsing done together with err.
REQ-024 Without DMEM_ALIGN_CHECK_EN, err SHALL be tied to 0 and every address SHALL follow the wrap rule of REQ-012.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- CPU write 0x11223344 to address 8, then CPU read of address 8 -> memory[8..11] = 11,22,33,44; c_rdata = 0x11223344; c_done 5 cycles after grant each time.
- c_req and d_req high together, both held across repeated transactions -> grants alternate CPU, debug, CPU; exactly one done per transaction.
- Write 0xAABBCCDD to address 62 (macro undefined) -> bytes land at 62, 63, 0, 1; err stays 0.
- Same write with DMEM_ALIGN_CHECK_EN defined -> m_we never high, done and err pulse together, memory unchanged.
- Reset asserted after beat 1 of a write of 0xCAFEBABE to address 0 -> outputs zero immediately, no done, memory[0..1] = CA,FE, memory[2..3] unchanged.
- d_req dropped mid-XFER -> transfer completes, d_done pulses once.
